// File: rtl/vga_display_controller_param_pkg.sv
// Shared defaults and types for the parametrised VGA display controller.
package vga_display_controller_param_pkg;

  // 640x480@60 raster with a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bits_t;

  localparam int SYNC_BITS_W = $bits(sync_bits_t);

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable shift register that delays the sync/active bits to match frame-buffer latency.
module vga_sync_delay #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_pre
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

  // q_pre is one stage short of q, so a register fed from it lines up with q
  generate
    if (DEPTH == 1) begin : g_single
      assign q_pre = d;
    end else begin : g_multi
      assign q_pre = stage[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_display_controller_param.sv
// Parametrised VGA timing, frame-buffer addressing, sync/blank alignment and frame-synchronous colour mask.
module vga_display_controller_param
  import vga_display_controller_param_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int CLK_DIV    = 2,
  parameter int SCALE_LOG2 = 0,
  parameter int FB_LATENCY = 1,
  parameter int COLOR_W    = 8,
  parameter int ADDR_W     = 19
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic               enable_vga_output_color,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [ADDR_W-1:0]  framebuff_addr_out,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic               vga_pixel_clk,
  output logic               frame_start,
  output logic               vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     SCALE_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
  localparam logic [DW-1:0]     DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic              HS_ON      = HS_POL[0];
  localparam logic              VS_ON      = VS_POL[0];
  localparam sync_bits_t        SYNC_IDLE  = '{hs: ~HS_ON, vs: ~VS_ON, active: 1'b0};

  logic [DW-1:0]     div_cnt;
  logic              pix_ce;
  logic [HW-1:0]     h_cnt, h_nxt;
  logic [VW-1:0]     v_cnt, v_nxt;
  logic [ADDR_W-1:0] row_base, row_nxt, addr_nxt;
  logic              en_latched, en_eff;
  sync_bits_t        sync_cur, sync_out, sync_pre;

  // DAC clock rises half-way through each pixel so the registered outputs are settled when sampled
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)      div_cnt <= '0;
    else if (pix_ce) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  assign pix_ce        = (div_cnt == DIV_LAST);
  assign vga_pixel_clk = (div_cnt >= DIV_HALF);

  always_comb begin
    h_nxt   = h_cnt + 1'b1;
    v_nxt   = v_cnt;
    row_nxt = row_base;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt   = '0;
        row_nxt = '0;
      end else begin
        v_nxt = v_cnt + 1'b1;
        if (v_cnt < V_ACT && ((v_cnt + 1'b1) & SCALE_MASK) == '0) row_nxt = row_base + ROW_STEP;
      end
    end
    addr_nxt = framebuff_addr_out;
    if (h_nxt < H_ACT && v_nxt < V_ACT) addr_nxt = row_nxt + ADDR_W'(h_nxt >> SCALE_LOG2);
  end

  // Address is registered one tick ahead so it belongs to the same pixel as the counters
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt              <= '0;
      v_cnt              <= '0;
      row_base           <= '0;
      framebuff_addr_out <= '0;
    end else if (pix_ce) begin
      h_cnt              <= h_nxt;
      v_cnt              <= v_nxt;
      row_base           <= row_nxt;
      framebuff_addr_out <= addr_nxt;
    end
  end

  always_comb begin
    sync_cur.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    sync_cur.hs     = (h_cnt >= HS_START && h_cnt < HS_END) ? HS_ON : ~HS_ON;
    sync_cur.vs     = (v_cnt >= VS_START && v_cnt < VS_END) ? VS_ON : ~VS_ON;
  end

  assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);
  assign vblank      = (v_cnt >= V_ACT);

  vga_sync_delay #(
    .WIDTH    (SYNC_BITS_W),
    .DEPTH    (FB_LATENCY + 1),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk_50),
    .rst_n(rst_n),
    .ce   (pix_ce),
    .d    (sync_cur),
    .q    (sync_out),
    .q_pre(sync_pre)
  );

  // With zero read latency the first pixel is captured on the frame_start tick itself
  assign en_eff = frame_start ? enable_vga_output_color : en_latched;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      en_latched <= 1'b0;
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
    end else if (pix_ce) begin
      if (frame_start) en_latched <= enable_vga_output_color;
      if (sync_pre.active && en_eff) begin
        red_out   <= red_in;
        green_out <= green_in;
        blue_out  <= blue_in;
      end else begin
        red_out   <= '0;
        green_out <= '0;
        blue_out  <= '0;
      end
    end
  end

  assign vga_hs      = sync_out.hs;
  assign vga_vs      = sync_out.vs;
  assign vga_blank_n = sync_out.active;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_display_controller_param.sv
// Randomised bench for the VGA controller on a reduced raster, checked against a pixel-position model.
module tb_vga_display_controller_param;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int HSP = 1, VSP = 0, CD = 4, SL = 1, LAT = 2, CW = 8, AW = 8;
  localparam int MAX_ADDR  = ((HA * VA) >> (2 * SL)) - 1;
  localparam int MAX_TICKS = 4096;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          enable_vga_output_color;
  logic [CW-1:0] red_in, green_in, blue_in;
  logic [CW-1:0] red_out, green_out, blue_out;
  logic [AW-1:0] framebuff_addr_out;
  logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_pixel_clk, frame_start, vblank;

  int       checkCount = 0;
  int       failCount  = 0;
  int       n;
  int       curTick;
  int       lastAddr;
  int       addrQ[$];
  int       modelAddr [MAX_TICKS];
  bit       enOfFrame [16];
  logic [7:0] ramR [256];
  logic [7:0] ramG [256];
  logic [7:0] ramB [256];

  always #10 clk_50 = ~clk_50;

  vga_display_controller_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CLK_DIV(CD), .SCALE_LOG2(SL),
    .FB_LATENCY(LAT), .COLOR_W(CW), .ADDR_W(AW)
  ) dut (
    .clk_50                 (clk_50),
    .rst_n                  (rst_n),
    .enable_vga_output_color(enable_vga_output_color),
    .red_in                 (red_in),
    .green_in               (green_in),
    .blue_in                (blue_in),
    .framebuff_addr_out     (framebuff_addr_out),
    .red_out                (red_out),
    .green_out              (green_out),
    .blue_out               (blue_out),
    .vga_hs                 (vga_hs),
    .vga_vs                 (vga_vs),
    .vga_blank_n            (vga_blank_n),
    .vga_sync_n             (vga_sync_n),
    .vga_pixel_clk          (vga_pixel_clk),
    .frame_start            (frame_start),
    .vblank                 (vblank)
  );

  function automatic int hPos(input int k);
    return (k % FT) % HT;
  endfunction

  function automatic int vPos(input int k);
    return (k % FT) / HT;
  endfunction

  function automatic bit isActive(input int k);
    return (hPos(k) < HA) && (vPos(k) < VA);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s tick=%0d got=%0h expected=%0h", tag, curTick, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    curTick = -1;
    checkOutput({tag, "_hs"},    32'(vga_hs), 32'(1 - HSP));
    checkOutput({tag, "_vs"},    32'(vga_vs), 32'(1 - VSP));
    checkOutput({tag, "_blank"}, 32'(vga_blank_n), 0);
    checkOutput({tag, "_rgb"},   {8'h0, red_out, green_out, blue_out}, 0);
    checkOutput({tag, "_addr"},  32'(framebuff_addr_out), 0);
    checkOutput({tag, "_pclk"},  32'(vga_pixel_clk), 0);
    checkOutput({tag, "_fs"},    32'(frame_start), 0);
    checkOutput({tag, "_vblank"}, 32'(vblank), 0);
  endtask

  // Called mid clock period; n counts rising edges since reset release
  task automatic verifyCycle();
    int div, k, j, expHs, expVs, expBlank, expR, expG, expB;
    div = n % CD;
    k = n / CD;
    curTick = k;
    if (div == 0) begin
      if (isActive(k)) lastAddr = (vPos(k) >> SL) * (HA >> SL) + (hPos(k) >> SL);
      modelAddr[k] = lastAddr;
    end
    checkOutput("pixel_clk",   32'(vga_pixel_clk), 32'(div >= CD / 2));
    checkOutput("frame_start", 32'(frame_start),   32'((div == CD - 1) && (k % FT == 0)));
    if (div == CD - 1) begin
      checkOutput("vblank",   32'(vblank), 32'(vPos(k) >= VA));
      checkOutput("addr",     32'(framebuff_addr_out), modelAddr[k]);
      checkOutput("addr_max", 32'(int'(framebuff_addr_out) > MAX_ADDR), 0);
      checkOutput("sync_n",   32'(vga_sync_n), 0);
      j = k - LAT - 1;
      if (j < 0) begin
        expHs = 1 - HSP; expVs = 1 - VSP; expBlank = 0; expR = 0; expG = 0; expB = 0;
      end else begin
        expHs = (hPos(j) >= HA + HFP && hPos(j) < HA + HFP + HSY) ? HSP : 1 - HSP;
        expVs = (vPos(j) >= VA + VFP && vPos(j) < VA + VFP + VSY) ? VSP : 1 - VSP;
        expBlank = int'(isActive(j));
        if (isActive(j) && enOfFrame[j / FT]) begin
          expR = ramR[modelAddr[j]]; expG = ramG[modelAddr[j]]; expB = ramB[modelAddr[j]];
        end else begin
          expR = 0; expG = 0; expB = 0;
        end
      end
      checkOutput("hs",      32'(vga_hs), expHs);
      checkOutput("vs",      32'(vga_vs), expVs);
      checkOutput("blank_n", 32'(vga_blank_n), expBlank);
      checkOutput("red",     32'(red_out), expR);
      checkOutput("green",   32'(green_out), expG);
      checkOutput("blue",    32'(blue_out), expB);
      if (k % FT == 0) enOfFrame[k / FT] = enable_vga_output_color;
      addrQ.push_back(int'(framebuff_addr_out));
      if (addrQ.size() > LAT) void'(addrQ.pop_front());
    end
  endtask

  // Frame-buffer RAM with LAT pixel ticks of read latency, plus random colour-enable toggles
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_50);
      verifyCycle();
      @(posedge clk_50);
      n++;
      #1;
      if (n % CD == 0) begin
        if (addrQ.size() == LAT) begin
          red_in = ramR[addrQ[0]]; green_in = ramG[addrQ[0]]; blue_in = ramB[addrQ[0]];
        end else begin
          red_in = '0; green_in = '0; blue_in = '0;
        end
        if (((n / CD) % FT == FT / 2) || ($urandom_range(0, 149) == 0))
          enable_vga_output_color = ~enable_vga_output_color;
      end
    end
  endtask

  task automatic restartModel();
    n = 0;
    lastAddr = 0;
    addrQ.delete();
    for (int i = 0; i < 16; i++) enOfFrame[i] = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ramR[i] = 8'($urandom); ramG[i] = 8'($urandom); ramB[i] = 8'($urandom);
    end
    rst_n = 1'b0;
    enable_vga_output_color = 1'b1;
    restartModel();
    repeat (3) @(posedge clk_50);
    #1;
    checkResetState("por");
    rst_n = 1'b1;
    applyStimulus(FT * CD * 2 + $urandom_range(FT * CD / 4, FT * CD * 3 / 4));

    #3 rst_n = 1'b0;
    #1 checkResetState("mid_rst");
    repeat (3) @(posedge clk_50);
    #1;
    checkResetState("mid_rst_hold");
    restartModel();
    rst_n = 1'b1;
    applyStimulus(FT * CD * 2 + 40);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
